writeback_arbiter: RTL and testbench

//  Drives the register file write port (RegWrite/Rd/Write_data) from two producers:

---
 rtl/writeback_arbiter.sv | 138 +++++++++++++
 tb/tb_writeback_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win, loads queue in an in-order FIFO
// and drain in ALU-idle cycles. Also flags read hazards against queued/staged writes.
module writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [4:0]                 ld_rd,
    input  logic [XLEN-1:0]            ld_data,
    input  logic [4:0]                 Rs1,
    input  logic [4:0]                 Rs2,
    output logic                       hz1,
    output logic                       hz2,
    output logic                       RegWrite,
    output logic [4:0]                 Rd,
    output logic [XLEN-1:0]            Write_data,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       entry_rd_q   [DEPTH];
    logic [4:0]       entry_rd_d   [DEPTH];
    logic [XLEN-1:0]  entry_data_q [DEPTH];
    logic [XLEN-1:0]  entry_data_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             regwrite_q, regwrite_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;

    logic push, pop, squash;

    // Depends on registered state only: a pop in a full cycle does not open a slot.
    assign ld_ready = !reset && (count_q < CW'(DEPTH));
    assign push     = ld_valid && ld_ready && (ld_rd != 5'd0);
    assign pop      = !alu_valid && (count_q != '0);
    assign squash   = alu_valid && (alu_rd != 5'd0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves a latch.
        valid_d      = valid_q;
        entry_rd_d   = entry_rd_q;
        entry_data_d = entry_data_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        regwrite_d   = 1'b0;
        rd_d         = rd_q;
        wdata_d      = wdata_q;

        if (alu_valid) begin
            regwrite_d = (alu_rd != 5'd0);
            rd_d       = alu_rd;
            wdata_d    = alu_data;
        end else if (pop) begin
            regwrite_d      = valid_q[head_q];
            rd_d            = entry_rd_q[head_q];
            wdata_d         = entry_data_q[head_q];
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end

        // Squash before push so an entry enqueued this cycle is treated as younger.
        if (squash) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (entry_rd_q[i] == alu_rd)) valid_d[i] = 1'b0;
            end
        end

        if (push) begin
            valid_d[tail_q]      = 1'b1;
            entry_rd_d[tail_q]   = ld_rd;
            entry_data_d[tail_q] = ld_data;
            tail_d               = tail_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        hz1 = 1'b0;
        hz2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entry_rd_q[i] == Rs1)) hz1 = 1'b1;
            if (valid_q[i] && (entry_rd_q[i] == Rs2)) hz2 = 1'b1;
        end
        if (regwrite_q && (rd_q == Rs1)) hz1 = 1'b1;
        if (regwrite_q && (rd_q == Rs2)) hz2 = 1'b1;
        hz1 = hz1 && (Rs1 != 5'd0);
        hz2 = hz2 && (Rs2 != 5'd0);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
        if (reset) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
        end
    end

    // NOTE: payload storage is not reset; the valid bits alone decide whether it is used.
    always_ff @(posedge clk) begin
        entry_rd_q   <= entry_rd_d;
        entry_data_q <= entry_data_d;
    end

    assign RegWrite   = regwrite_q;
    assign Rd         = rd_q;
    assign Write_data = wdata_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, ALU path, load FIFO order, rd==0 drops,
// WAW squash, push/pop overlap, hazards and mid-operation reset.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  Rs1, Rs2;
    logic        hz1, hz2;
    logic        RegWrite;
    logic [4:0]  Rd;
    logic [31:0] Write_data;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    writeback_arbiter #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .Rs1(Rs1), .Rs2(Rs2), .hz1(hz1), .hz2(hz2),
        .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are then read 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        step(); step();
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready got=%b exp=0", ld_ready); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got=%b exp=0", RegWrite); end
        checks++; if (Rd !== 5'd0) begin errors++; $display("FAIL rst_rd got=%0d exp=0", Rd); end
        checks++; if (Write_data !== 32'd0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", Write_data); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
        reset = 1'b0; ld_valid = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ld_ready got=%b exp=1", ld_ready); end
        step();
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL alu_we got=%b exp=1", RegWrite); end
        checks++; if (Rd !== 5'd5) begin errors++; $display("FAIL alu_rd got=%0d exp=5", Rd); end
        checks++; if (Write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_data got=%h exp=deadbeef", Write_data); end
        step();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL alu_we_drop got=%b exp=0", RegWrite); end
        checks++; if (Rd !== 5'd5) begin errors++; $display("FAIL alu_rd_hold got=%0d exp=5", Rd); end
    endtask

    task automatic test_fifo_order();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            ld_valid = 1'b1; ld_rd = 5'(i); ld_data = 32'(i * 32'h11);
            #1;
            checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, ld_ready); end
            step();
            checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL fill_we[%0d] got=%b exp=0", i, RegWrite); end
            checks++; if (fifo_count !== 3'(i)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, fifo_count, i); end
        end
        // Full with a pop in the same cycle: still no acceptance.
        alu_valid = 1'b0; ld_rd = 5'd10; ld_data = 32'hBAD;
        #1;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", ld_ready); end
        for (int k = 1; k <= 4; k++) begin
            step();
            ld_valid = 1'b0;
            checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL drain_we[%0d] got=%b exp=1", k, RegWrite); end
            checks++; if (Rd !== 5'(k)) begin errors++; $display("FAIL drain_rd[%0d] got=%0d exp=%0d", k, Rd, k); end
            checks++; if (Write_data !== 32'(k * 32'h11)) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", k, Write_data, k * 32'h11); end
            checks++; if (fifo_count !== 3'(4 - k)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", k, fifo_count, 4 - k); end
        end
        step();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL drain_end_we got=%b exp=0", RegWrite); end
    endtask

    task automatic test_rd_zero();
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h77;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready got=%b exp=1", ld_ready); end
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rd0_count got=%0d exp=0", fifo_count); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rd0_we got=%b exp=0", RegWrite); end
        step();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rd0_we2 got=%b exp=0", RegWrite); end
    endtask

    task automatic test_back_to_back();
        alu_valid = 1'b1; alu_rd = 5'd0;
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h12;
        step();
        alu_valid = 1'b0; ld_rd = 5'd13; ld_data = 32'h13;
        step();
        ld_valid = 1'b0;
        checks++; if (Rd !== 5'd12 || RegWrite !== 1'b1) begin errors++; $display("FAIL b2b_first got=%b/%0d exp=1/12", RegWrite, Rd); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_count got=%0d exp=1", fifo_count); end
        step();
        checks++; if (Rd !== 5'd13 || Write_data !== 32'h13) begin errors++; $display("FAIL b2b_second got=%0d/%h exp=13/13", Rd, Write_data); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_empty got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_waw_squash();
        alu_valid = 1'b1; alu_rd = 5'd0;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hAA;
        step();
        ld_valid = 1'b0; alu_rd = 5'd7; alu_data = 32'hBB;
        step();
        alu_valid = 1'b0;
        checks++; if (RegWrite !== 1'b1 || Rd !== 5'd7 || Write_data !== 32'hBB) begin
            errors++; $display("FAIL waw_alu got=%b/%0d/%h exp=1/7/bb", RegWrite, Rd, Write_data); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL waw_slot got=%0d exp=1", fifo_count); end
        step();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL waw_squashed_we got=%b exp=0", RegWrite); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL waw_drain_count got=%0d exp=0", fifo_count); end
        // Younger load pushed alongside the ALU write survives.
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h80;
        ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h88;
        step();
        alu_valid = 1'b0; ld_valid = 1'b0;
        checks++; if (Write_data !== 32'h80 || RegWrite !== 1'b1) begin errors++; $display("FAIL young_alu got=%b/%h exp=1/80", RegWrite, Write_data); end
        step();
        checks++; if (RegWrite !== 1'b1 || Rd !== 5'd8 || Write_data !== 32'h88) begin
            errors++; $display("FAIL young_load got=%b/%0d/%h exp=1/8/88", RegWrite, Rd, Write_data); end
        step();
    endtask

    task automatic test_hazard_and_reset();
        alu_valid = 1'b1; alu_rd = 5'd0;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        step();
        ld_valid = 1'b0; Rs1 = 5'd9; Rs2 = 5'd0;
        #1;
        checks++; if (hz1 !== 1'b1) begin errors++; $display("FAIL hz1_queued got=%b exp=1", hz1); end
        checks++; if (hz2 !== 1'b0) begin errors++; $display("FAIL hz2_r0 got=%b exp=0", hz2); end
        alu_rd = 5'd20; Rs2 = 5'd20;
        #1;
        checks++; if (hz2 !== 1'b0) begin errors++; $display("FAIL hz2_alu_input got=%b exp=0", hz2); end
        alu_valid = 1'b0; alu_rd = 5'd0; Rs2 = 5'd0;
        step();
        checks++; if (hz1 !== 1'b1 || RegWrite !== 1'b1 || Rd !== 5'd9) begin
            errors++; $display("FAIL hz1_staged got=%b/%b/%0d exp=1/1/9", hz1, RegWrite, Rd); end
        step();
        checks++; if (hz1 !== 1'b0) begin errors++; $display("FAIL hz1_clear got=%b exp=0", hz1); end
        // Mid-operation reset with three loads queued.
        alu_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ld_valid = 1'b1; ld_rd = 5'(i); ld_data = 32'(i);
            step();
        end
        ld_valid = 1'b0;
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL pre_rst_count got=%0d exp=3", fifo_count); end
        alu_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; Rs1 = 5'd1;
        #1;
        checks++; if (fifo_count !== 3'd0 || RegWrite !== 1'b0) begin errors++; $display("FAIL mid_rst got=%0d/%b exp=0/0", fifo_count, RegWrite); end
        checks++; if (hz1 !== 1'b0) begin errors++; $display("FAIL mid_rst_hz got=%b exp=0", hz1); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL post_rst_we[%0d] got=%b exp=0", k, RegWrite); end
        end
    endtask

    initial begin
        reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0; Rs1 = '0; Rs2 = '0;
        #1;
        test_reset();
        test_alu();
        test_fifo_order();
        test_rd_zero();
        test_back_to_back();
        test_waw_squash();
        test_hazard_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
